pau: RTL and testbench
======================

# pau

Parametrised, pipelined partitioned arithmetic unit; the next-generation add/sub/packed-add datapath for the execute stage. Performs full-width or per-lane signed add/subtract with overflow saturation. Results and condition flags pass through a two-stage pipeline with valid/ready flow control. Sits between the operand-read stage and writeback, alongside the logic unit and shifter.

## Interface
- `WIDTH`, 16: datapath width; must be a multiple of `LANE_W`.
- `LANE_W`, 8: lane width for packed modes; `LANES = WIDTH/LANE_W`, at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operands and command are valid.
- `in_ready`  out  1  unit accepts an operation this cycle.
- `cmd`  in  2  operation: 00 ADD, 01 SUB, 10 PADD (per-lane add), 11 PSUB (per-lane sub).
- `a`, `b`  in  WIDTH  signed operands.
- `out_valid`  out  1  result and flags are valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  WIDTH  saturated (or wrapped) result.
- `lane_v`  out  LANES  per-lane overflow; in ADD/SUB, all bits equal `v`.
- `v`  out  1  overflow of the top lane (the whole word in ADD/SUB).
- `n`  out  1  true sign of the top lane: `sum_msb ^ v`.
- `z`  out  1  final `result == 0`.
- `cout`  out  1  carry out of the MSB; for subtract, 1 means no borrow.

## Operation
- Subtraction is computed as `a + ~b + 1`; the `+1` is injected as carry-in of every lane in PSUB, and of lane 0 only in SUB.
- ADD/SUB: the carry propagates across lane boundaries, so the word is treated as a single WIDTH-bit lane.
- PADD/PSUB: the carry into every lane boundary is forced to the mode carry-in (0 for add, 1 for sub); no inter-lane propagation.
- Per-lane overflow: operand sign bits (b sign after inversion) are equal and differ from the sum sign.
- Saturation per overflowing lane:
  - true sign 0 gives `0111…1`;
  - true sign 1 gives `1000…0`.
  - Non-overflowing lanes pass the raw sum.
- Stage S1 registers the raw sums, per-lane carries, per-lane overflow and `cmd`. Stage S2 registers the saturated result and `v/n/z/cout/lane_v`.
- Flow control:
  - A stage loads when it is empty or its contents move on this cycle.
  - `in_ready = ~s1_valid | s1_advance`, where `s1_advance = ~s2_valid | out_ready`.
  - Full throughput is one operation per cycle.
- `in_ready` is combinational from `out_ready` and the stage valids, never from `in_valid`.
- The output holds stable (`result`, flags, `out_valid`) while `out_valid & ~out_ready`.
- Reset state (`rst_n` low at an edge):
  - S1 and S2 valids are 0;
  - `result`, `lane_v`, `v`, `n`, `z`, `cout` are 0;
  - `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Reset mid-operation discards all in-flight operations; no output is produced for them.

## Timing
- Latency is 2 cycles: an operation accepted at edge k presents `out_valid` after edge k+2 when unstalled.
- Back-to-back accepts produce results on consecutive cycles in order.
- With `out_ready` low, at most 2 operations are held (S1 + S2); `in_ready` deasserts once both are full.
- Simultaneous accept and drain in a full pipe keeps it full, with `in_ready` = 1.
- `z` and `n` reflect the final (saturated) result; `cout` and `lane_v` reflect the raw sum.

## Configuration
- `PAU_SAT_EN` defined: overflowing lanes saturate as described.
- `PAU_SAT_EN` undefined: `result` is the raw modular sum.
  - `v`, `lane_v` and `cout` are still reported.
  - `n` is `result[WIDTH-1]`.
  - Saturation logic is not synthesised.

## Test plan
All scenarios use WIDTH=16, LANE_W=8.
- ADD 0x7FFF+0x0001 -> `result` 0x7FFF, `v`=1, `n`=0, `z`=0, `cout`=0 (without `PAU_SAT_EN`: 0x8000, `n`=1).
- SUB 0x8000-0x0001 -> `result` 0x8000, `v`=1, `n`=1, `lane_v`=11.
- PADD 0x7F80+0x0180 -> `result` 0x7F80, `lane_v`=11, `v`=1, `n`=0, `cout`=0; lane 0 is not propagated into lane 1.
- PSUB 0x0501-0x0302 -> `result` 0x02FF, `lane_v`=00, `v`=0, `n`=0, `cout`=1; SUB 0x0000-0x0000 -> `result` 0x0000, `z`=1, `cout`=1.
- Three back-to-back ops with `out_ready` low for 4 cycles -> `in_ready` drops after two accepts; the third op is held at the input; all three results emerge in order with no loss or duplication.
- `rst_n` low for 1 cycle with 2 ops in flight -> `out_valid`=0 and all outputs 0 the next cycle; `in_ready`=1 the cycle after release; a subsequent op completes with 2-cycle latency.

Source files
------------

// File: rtl/pau.sv
// pau: two-stage pipelined partitioned add/sub with per-lane overflow flags.
// Lane saturation is built only when PAU_SAT_EN is defined; otherwise result wraps.
module pau #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                cmd,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          result,
    output logic [WIDTH/LANE_W-1:0]   lane_v,
    output logic                      v,
    output logic                      n,
    output logic                      z,
    output logic                      cout
);
    localparam int LANES = WIDTH / LANE_W;

    logic              s1_advance, accept, load;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]  s1_sum_q, s1_sum_d, res_q, res_d;
    logic [LANES-1:0]  s1_ovf_q, s1_ovf_d, lane_v_q, lane_v_d;
    logic              s1_cout_q, s1_cout_d, s1_packed_q, s1_packed_d;
    logic              v_q, v_d, n_q, n_d, z_q, z_d, cout_q, cout_d;
    logic [WIDTH-1:0]  bx, sum, fin;
    logic [LANES-1:0]  ovf;
    logic [LANE_W:0]   ls;
    logic              c;

    assign s1_advance = ~s2_valid_q | out_ready;
    assign in_ready   = rst_n & (~s1_valid_q | s1_advance);
    assign accept     = in_valid & in_ready;
    assign load       = s1_advance & s1_valid_q;

    // Packed modes force every lane's carry-in to the mode carry; word modes chain lanes.
    always_comb begin
        bx  = cmd[0] ? ~b : b;
        sum = '0;
        ovf = '0;
        ls  = '0;
        c   = cmd[0];
        for (int i = 0; i < LANES; i++) begin
            ls = {1'b0, a[i*LANE_W +: LANE_W]} + {1'b0, bx[i*LANE_W +: LANE_W]}
               + {{LANE_W{1'b0}}, cmd[1] ? cmd[0] : c};
            sum[i*LANE_W +: LANE_W] = ls[LANE_W-1:0];
            ovf[i] = (a[(i+1)*LANE_W-1] == bx[(i+1)*LANE_W-1]) && (ls[LANE_W-1] != a[(i+1)*LANE_W-1]);
            c = ls[LANE_W];
        end
        s1_valid_d  = in_ready ? in_valid : s1_valid_q;
        s1_sum_d    = accept ? sum : s1_sum_q;
        s1_ovf_d    = accept ? ovf : s1_ovf_q;
        s1_cout_d   = accept ? c : s1_cout_q;
        s1_packed_d = accept ? cmd[1] : s1_packed_q;
    end

    always_comb begin
        fin = s1_sum_q;
`ifdef PAU_SAT_EN
        if (s1_packed_q) begin
            for (int i = 0; i < LANES; i++)
                if (s1_ovf_q[i])
                    fin[i*LANE_W +: LANE_W] = {~s1_sum_q[(i+1)*LANE_W-1], {(LANE_W-1){s1_sum_q[(i+1)*LANE_W-1]}}};
        end else if (s1_ovf_q[LANES-1]) begin
            fin = {~s1_sum_q[WIDTH-1], {(WIDTH-1){s1_sum_q[WIDTH-1]}}};
        end
        n_d = load ? s1_sum_q[WIDTH-1] ^ s1_ovf_q[LANES-1] : n_q;
`else
        n_d = load ? fin[WIDTH-1] : n_q;
`endif
        s2_valid_d = s1_advance ? s1_valid_q : s2_valid_q;
        res_d      = load ? fin : res_q;
        lane_v_d   = load ? (s1_packed_q ? s1_ovf_q : {LANES{s1_ovf_q[LANES-1]}}) : lane_v_q;
        v_d        = load ? s1_ovf_q[LANES-1] : v_q;
        z_d        = load ? (fin == '0) : z_q;
        cout_d     = load ? s1_cout_q : cout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_ovf_q    <= '0;
            s1_cout_q   <= 1'b0;
            s1_packed_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            res_q       <= '0;
            lane_v_q    <= '0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_ovf_q    <= s1_ovf_d;
            s1_cout_q   <= s1_cout_d;
            s1_packed_q <= s1_packed_d;
            s2_valid_q  <= s2_valid_d;
            res_q       <= res_d;
            lane_v_q    <= lane_v_d;
            v_q         <= v_d;
            n_q         <= n_d;
            z_q         <= z_d;
            cout_q      <= cout_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign lane_v    = lane_v_q;
    assign v         = v_q;
    assign n         = n_q;
    assign z         = z_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_pau.sv
// tb_pau: scoreboard bench for pau (WIDTH=16, LANE_W=8); expectations track PAU_SAT_EN.
module tb_pau;
    typedef struct packed {
        logic [15:0] r;
        logic [1:0]  lv;
        logic        v, n, z, c;
    } exp_t;

`ifdef PAU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  cmd = '0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, v, n, z, cout;
    logic [15:0] result;
    logic [1:0]  lane_v;

    exp_t q[$];
    exp_t cur_exp = '0;
    int   tests = 0, fails = 0;
    bit   rand_rdy = 1'b0, rdy_force = 1'b0;

    pau #(.WIDTH(16), .LANE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .lane_v(lane_v), .v(v), .n(n), .z(z), .cout(cout)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] r, input logic [1:0] lv,
                                input logic vv, nn, zz, cc);
        exp_t e;
        e.r = r; e.lv = lv; e.v = vv; e.n = nn; e.z = zz; e.c = cc;
        return e;
    endfunction

    // Mathematical reference: signed lane arithmetic in wide integers, clamped on overflow.
    function automatic exp_t model(input logic [1:0] c, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int lw, nl;
        longint m, ua, ub, sa, sb, r, s;
        bit o;
        logic [15:0] raw;
        e = '0; raw = '0;
        lw = c[1] ? 8 : 16;
        nl = 16 / lw;
        m  = longint'(1) << lw;
        for (int i = 0; i < nl; i++) begin
            ua = longint'(x >> (i*lw)) & (m - 1);
            ub = longint'(y >> (i*lw)) & (m - 1);
            sa = (ua >= m/2) ? ua - m : ua;
            sb = (ub >= m/2) ? ub - m : ub;
            r  = c[0] ? sa - sb : sa + sb;
            o  = (r >= m/2) || (r < -(m/2));
            s  = (SAT && o) ? ((r > 0) ? m/2 - 1 : m/2) : r;
            raw = raw | 16'((((s % m) + m) % m) << (i*lw));
            if (nl == 1) e.lv = {o, o};
            else e.lv[i] = o;
            if (i == nl - 1) begin
                e.v = o;
                e.c = c[0] ? (ua >= ub) : (ua + ub >= m);
                e.n = SAT ? (r < 0) : raw[15];
            end
        end
        e.r = raw;
        e.z = (raw == 16'h0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] x, input logic [15:0] y, input exp_t e);
        int k;
        k = 0;
        cmd = c; a = x; b = y; cur_exp = e; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 50) begin
                tests++; fails++;
                $display("FAIL send_timeout in_ready stuck at 0, required 1 within 50 cycles");
                break;
            end
        end
        step();
        in_valid = 1'b0;
    endtask

    always @(negedge clk)
        if (in_valid && in_ready) q.push_back(cur_exp);

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Pops on every handshake; also requires outputs to hold while stalled.
    exp_t hold_val;
    bit   hold = 1'b0;
    always @(negedge clk) begin : mon
        exp_t got, e;
        got = mk(result, lane_v, v, n, z, cout);
        if (hold && rst_n) begin
            tests++;
            if (!out_valid || got !== hold_val) begin
                fails++;
                $display("FAIL stall_hold got valid=%b out=%h required valid=1 out=%h", out_valid, got, hold_val);
            end
        end
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output got r=%h with no operation outstanding", got.r);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL result got r=%h lv=%b v=%b n=%b z=%b c=%b required r=%h lv=%b v=%b n=%b z=%b c=%b",
                             got.r, got.lv, got.v, got.n, got.z, got.c, e.r, e.lv, e.v, e.n, e.z, e.c);
                end
            end
        end
        hold = rst_n && out_valid && !out_ready;
        hold_val = got;
    end

    logic [15:0] corners [8] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h7F80, 16'h8080, 16'h017F};

    function automatic logic [15:0] pick();
        return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : 16'($urandom);
    endfunction

    initial begin
        logic [1:0]  dc [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        logic [15:0] da [5] = '{16'h7FFF, 16'h8000, 16'h7F80, 16'h0501, 16'h0000};
        logic [15:0] db [5] = '{16'h0001, 16'h0001, 16'h0180, 16'h0302, 16'h0000};
        exp_t de [5];
        logic [1:0]  c;
        logic [15:0] x, y;
        int k;
        if (SAT) begin
            de[0] = mk(16'h7FFF, 2'b11, 1, 0, 0, 0);
            de[1] = mk(16'h8000, 2'b11, 1, 1, 0, 1);
            de[2] = mk(16'h7F80, 2'b11, 1, 0, 0, 0);
        end else begin
            de[0] = mk(16'h8000, 2'b11, 1, 1, 0, 0);
            de[1] = mk(16'h7FFF, 2'b11, 1, 0, 0, 1);
            de[2] = mk(16'h8000, 2'b11, 1, 1, 0, 0);
        end
        de[3] = mk(16'h02FF, 2'b00, 0, 0, 0, 1);
        de[4] = mk(16'h0000, 2'b00, 0, 0, 1, 1);

        step(); step();
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_outputs", {out_valid, result, lane_v, v, n, z, cout}, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        step();

        rdy_force = 1'b1;
        for (int i = 0; i < 5; i++) send(dc[i], da[i], db[i], de[i]);
        repeat (3) step();

        rdy_force = 1'b0;
        send(2'b00, 16'h1234, 16'h1111, model(2'b00, 16'h1234, 16'h1111));
        send(2'b11, 16'h8001, 16'h0102, model(2'b11, 16'h8001, 16'h0102));
        cmd = 2'b10; a = 16'h7F7F; b = 16'h0101; cur_exp = model(2'b10, 16'h7F7F, 16'h0101);
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("full_out_valid", out_valid, 1);
            step();
        end
        rdy_force = 1'b1;
        @(negedge clk);
        chk("accept_and_drain_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("inorder_all_drained", q.size(), 0);

        rdy_force = 1'b0;
        send(2'b01, 16'h4000, 16'h0123, model(2'b01, 16'h4000, 16'h0123));
        send(2'b10, 16'h1020, 16'h3040, model(2'b10, 16'h1020, 16'h3040));
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {out_valid, result, lane_v, v, n, z, cout}, 0);
        chk("midrst_in_ready_after", in_ready, 1);
        step();
        rdy_force = 1'b1;
        cmd = 2'b00; a = 16'h0100; b = 16'h00FF; cur_exp = model(2'b00, 16'h0100, 16'h00FF);
        in_valid = 1'b1;
        @(negedge clk);
        chk("latency_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_edge1", out_valid, 0);
        @(negedge clk);
        chk("latency_edge2", out_valid, 1);
        step();

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            c = 2'($urandom);
            x = pick();
            y = pick();
            send(c, x, y, model(c, x, y));
        end
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        chk("final_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
